pe_host_responder: RTL
======================

# pe_host_responder

Memory-side responder for the matrix-vector PE controller. It holds the operand RAM the controller streams from over its `raddr`/`rddata` read port and captures the result words the controller emits on `write`/`wrdata`. It sequences one run (`start` pulse, wait for `done`) and gives a host a simple load / go / readback interface with completion and error reporting.

## Interface
- `VECTOR_SIZE`, 16: vector length; row length of the matrix.
- `MATRIX_SIZE`, 16: number of matrix rows and number of result words.
- `TIMEOUT_CYCLES`, 65535: maximum cycles in RUN before abort.
- `IN_DEPTH`, derived: `(MATRIX_SIZE+1)*VECTOR_SIZE+1`, the operand RAM depth in words.

Ports (clock and reset first):
- `aclk` in 1: single clock; all logic is on the rising edge.
- `areset_n` in 1: asynchronous, active-low reset.
- `h_we` in 1: host operand write strobe.
- `h_waddr` in 32: operand word address.
- `h_wdata` in 32: operand data.
- `h_go` in 1: request a run.
- `h_raddr` in 32: result index to read back.
- `h_rdata` out 32: result word, registered.
- `h_busy` out 1: high in any state other than IDLE.
- `h_irq` out 1: one-cycle completion pulse.
- `h_err` out 3: sticky error bits `{timeout, count, range}`; cleared by `h_go`.
- `pe_start` out 1: one-cycle start pulse to the controller.
- `pe_done` in 1: controller done level.
- `pe_write` in 1: controller result-valid level.
- `pe_raddr` in 32: controller address bus. It addresses operands outside WRITE and gives the result index during `pe_write`.
- `pe_rddata` out 32: operand read data.
- `pe_wrdata` in 32: result data.

## Operation
- **State machine:** IDLE, START, RUN, FINISH.
  - IDLE -> START on `h_go`.
  - START -> RUN unconditionally.
  - RUN -> FINISH on the rising edge of `pe_done`, or when the timeout counter reaches 0.
  - FINISH -> IDLE unconditionally.
- **Operand RAM:** `IN_DEPTH` x 32.
  - Host writes are accepted only in IDLE.
  - `h_we` outside IDLE is dropped and sets `range`.
  - `h_waddr >= IN_DEPTH` is dropped and sets `range`.
- **Operand read:** every cycle, `pe_rddata` is the RAM word at the `pe_raddr` sampled on the previous edge.
  - Out-of-range addresses return 0 and set `range`, but only while in RUN.
- **Result capture:** in RUN with `pe_write=1`, `pe_wrdata` is stored at index `pe_raddr`.
  - Index `>= MATRIX_SIZE` is dropped and sets `range`.
  - Each accepted write increments `wr_cnt`.
  - In FINISH, `wr_cnt != MATRIX_SIZE` sets `count`.
- **Result readback:** `h_rdata` is the result RAM word at the `h_raddr` sampled on the previous edge. Out-of-range returns 0.
  - Readback is valid in every state; result contents persist across runs until overwritten.
- **Timeout:** on entry to RUN the counter loads `TIMEOUT_CYCLES` and decrements each RUN cycle. Expiry sets `timeout` and goes to FINISH.
- **`h_go` handling:** `h_go` clears `h_err` and `wr_cnt` in the same edge that enters START. `h_go` while busy is ignored; no error is raised.
- **`h_irq`:** asserted during FINISH, for both normal completion and timeout.

## Timing
- **Reset values:** state IDLE; `pe_start`, `h_busy`, `h_irq` = 0; `h_err` = 0; `h_rdata`, `pe_rddata` = 0; `wr_cnt` = 0. RAM contents are not reset.
- **Start sequence:** `h_go` at edge N gives `pe_start=1` for cycle N+1 only and `h_busy=1` from N+1.
- **Done edge:** `pe_done` is detected by edge; a registered previous value is kept. If `pe_done` is already high on entry to RUN, nothing happens until it falls and rises again.
- **Completion latency:** a `pe_done` rise sampled at edge M gives FINISH (`h_irq=1`) in cycle M+1 and IDLE at M+2.
- **Read latency:** both read ports have exactly 1 cycle of latency, back-to-back, with no stall.
- **Collisions:** the host port and PE port never collide on the operand RAM (host is IDLE-only). A host read and a PE write on the result RAM in the same cycle returns the old data.
- **Simultaneous events:** if `pe_done` rises in the same cycle the timeout expires, the transition is treated as done; `timeout` is not set.
- **Mid-operation reset:** reset asserted mid-run returns to IDLE asynchronously and deasserts `pe_start`/`h_irq` immediately.

## Structure
- **Shared package:** state enum, `h_err` bit positions, and the `IN_DEPTH` computation, so the controller bench shares them.
- **Sub-module:** one, `pe_dp_ram`: a parameterized 1-write/1-read synchronous RAM with registered read. It is instantiated twice, once for operands and once for results.

## Test plan
- **Reset:** reset with `h_go=1` held -> all outputs 0; after release, `pe_start` pulses exactly once, 1 cycle after the first sampled `h_go`.
- **Operand reads:** host loads word k with value k*3 for k=0..272, then the PE bus reads addresses 272 down to 0 -> `pe_rddata` = 816 down to 0, each one cycle after its address.
- **Normal run:** 16 `pe_write` cycles at indices 0..15 with data 0x100+i, then `pe_done` rises -> `h_irq` 1 cycle later, `h_err`=0, readback of index 5 = 0x105.
- **Short run:** only 15 writes before `pe_done` -> `h_err`=3'b010. Index 16 write -> `range` set and the result RAM is unchanged.
- **Timeout:** with `TIMEOUT_CYCLES`=10, `pe_done` never rises -> `h_irq` in the 11th RUN-derived cycle and `h_err`=3'b100. With `pe_done` rising on the expiry cycle -> `h_err`=0.
- **Busy protection:** `h_we` and `h_go` while busy -> operand RAM is unchanged, `range` is set, and no second `pe_start`.

Source files
------------

// File: rtl/pe_host_responder_pkg.sv
// Shared types and sizing for the PE host responder and the controller bench.
package pe_host_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_START  = 2'd1,
    ST_RUN    = 2'd2,
    ST_FINISH = 2'd3
  } state_t;

  localparam int ERR_RANGE   = 0;
  localparam int ERR_COUNT   = 1;
  localparam int ERR_TIMEOUT = 2;

  // Matrix rows plus the vector, plus one spare word.
  function automatic int calc_in_depth(input int vector_size, input int matrix_size);
    return (matrix_size + 1) * vector_size + 1;
  endfunction

endpackage

// File: rtl/pe_dp_ram.sv
// One-write/one-read synchronous RAM with a registered read port.
// Disabled reads return 0; a same-edge read and write to one word returns the old word.
module pe_dp_ram #(
  parameter int DEPTH = 16,
  parameter int WIDTH = 32,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
    else         rdata <= '0;
  end

endmodule

// File: rtl/pe_host_responder.sv
// Memory-side responder for the matrix-vector PE: operand RAM, result capture,
// run sequencing with timeout, and a host load / go / readback port.
module pe_host_responder
  import pe_host_responder_pkg::*;
#(
  parameter int VECTOR_SIZE    = 16,
  parameter int MATRIX_SIZE    = 16,
  parameter int TIMEOUT_CYCLES = 65535
) (
  input  logic        aclk,
  input  logic        areset_n,
  input  logic        h_we,
  input  logic [31:0] h_waddr,
  input  logic [31:0] h_wdata,
  input  logic        h_go,
  input  logic [31:0] h_raddr,
  output logic [31:0] h_rdata,
  output logic        h_busy,
  output logic        h_irq,
  output logic [2:0]  h_err,
  output logic        pe_start,
  input  logic        pe_done,
  input  logic        pe_write,
  input  logic [31:0] pe_raddr,
  output logic [31:0] pe_rddata,
  input  logic [31:0] pe_wrdata
);

  localparam int IN_DEPTH = calc_in_depth(VECTOR_SIZE, MATRIX_SIZE);
  localparam int IN_AW    = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
  localparam int RES_AW   = (MATRIX_SIZE > 1) ? $clog2(MATRIX_SIZE) : 1;

  state_t      state;
  logic        done_q;
  logic [31:0] tmo_cnt;
  logic [31:0] wr_cnt;
  logic [2:0]  err_set;

  logic host_wr_ok, pe_rd_ok, res_idx_ok, res_we, res_re, done_rise;

  assign host_wr_ok = (state == ST_IDLE) && (h_waddr < 32'(IN_DEPTH));
  assign pe_rd_ok   = pe_raddr < 32'(IN_DEPTH);
  assign res_idx_ok = pe_raddr < 32'(MATRIX_SIZE);
  assign res_we     = (state == ST_RUN) && pe_write && res_idx_ok;
  assign res_re     = h_raddr < 32'(MATRIX_SIZE);
  assign done_rise  = pe_done && !done_q;

  // During pe_write the address bus carries a result index, not an operand address.
  always_comb begin
    err_set              = '0;
    err_set[ERR_RANGE]   = (h_we && !host_wr_ok) ||
                           ((state == ST_RUN) && (pe_write ? !res_idx_ok : !pe_rd_ok));
    err_set[ERR_COUNT]   = (state == ST_FINISH) && (wr_cnt != 32'(MATRIX_SIZE));
    err_set[ERR_TIMEOUT] = (state == ST_RUN) && !done_rise && (tmo_cnt <= 32'd1);
  end

  always_ff @(posedge aclk or negedge areset_n) begin
    if (!areset_n) begin
      state    <= ST_IDLE;
      pe_start <= 1'b0;
      h_busy   <= 1'b0;
      h_irq    <= 1'b0;
      h_err    <= 3'b000;
      wr_cnt   <= '0;
      tmo_cnt  <= '0;
      done_q   <= 1'b0;
    end else begin
      done_q   <= pe_done;
      pe_start <= 1'b0;
      h_irq    <= 1'b0;
      h_err    <= (((state == ST_IDLE) && h_go) ? 3'b000 : h_err) | err_set;
      case (state)
        ST_IDLE: if (h_go) begin
          state    <= ST_START;
          pe_start <= 1'b1;
          h_busy   <= 1'b1;
          wr_cnt   <= '0;
        end
        ST_START: begin
          state   <= ST_RUN;
          tmo_cnt <= 32'(TIMEOUT_CYCLES);
        end
        ST_RUN: begin
          if (res_we) wr_cnt <= wr_cnt + 32'd1;
          // A done edge on the expiry cycle wins; err_set already masks the timeout.
          if (done_rise || (tmo_cnt <= 32'd1)) begin
            state <= ST_FINISH;
            h_irq <= 1'b1;
          end else begin
            tmo_cnt <= tmo_cnt - 32'd1;
          end
        end
        ST_FINISH: begin
          state  <= ST_IDLE;
          h_busy <= 1'b0;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  pe_dp_ram #(.DEPTH(IN_DEPTH), .WIDTH(32), .AW(IN_AW)) u_operand_ram (
    .clk   (aclk),
    .rst_n (areset_n),
    .we    (h_we && host_wr_ok),
    .waddr (h_waddr[IN_AW-1:0]),
    .wdata (h_wdata),
    .re    (pe_rd_ok),
    .raddr (pe_raddr[IN_AW-1:0]),
    .rdata (pe_rddata)
  );

  pe_dp_ram #(.DEPTH(MATRIX_SIZE), .WIDTH(32), .AW(RES_AW)) u_result_ram (
    .clk   (aclk),
    .rst_n (areset_n),
    .we    (res_we),
    .waddr (pe_raddr[RES_AW-1:0]),
    .wdata (pe_wrdata),
    .re    (res_re),
    .raddr (h_raddr[RES_AW-1:0]),
    .rdata (h_rdata)
  );

endmodule
